// File: rtl/operand_select_stage.sv
`default_nettype none
// ============================================================================
//  Module   : operand_select_stage
//  Purpose  : VCPU-32 execute-stage front end. Resolves A/B operands with
//             EX/MA bypassing, detects load-use hazards, and holds the
//             selected operands in a one-entry register toward the ALU.
//  Revision : 1.0  initial release
// ============================================================================
module operand_select_stage #(
    parameter int WIDTH = 32,
    parameter int RID   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [0:RID-1]   inRegA,
    input  logic [0:RID-1]   inRegB,
    input  logic [0:WIDTH-1] inValA,
    input  logic [0:WIDTH-1] inValB,
    input  logic [0:WIDTH-1] inImm,
    input  logic             inUseImm,
    input  logic [0:7]       inAluCtl,
    input  logic [0:RID-1]   inDstReg,
    input  logic             inDstWe,
    input  logic             fwdExValid,
    input  logic             fwdExLoad,
    input  logic [0:RID-1]   fwdExReg,
    input  logic [0:WIDTH-1] fwdExVal,
    input  logic             fwdMaValid,
    input  logic [0:RID-1]   fwdMaReg,
    input  logic [0:WIDTH-1] fwdMaVal,
    input  logic             flush,
    output logic             outValid,
    input  logic             outReady,
    output logic [0:WIDTH-1] outA,
    output logic [0:WIDTH-1] outB,
    output logic [0:7]       outAluCtl,
    output logic [0:RID-1]   outDstReg,
    output logic             outDstWe,
    output logic [15:0]      stallCnt
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [0:WIDTH-1] a_q, a_d;
    logic [0:WIDTH-1] b_q, b_d;
    logic [0:7]       ctl_q, ctl_d;
    logic [0:RID-1]   dst_q, dst_d;
    logic             we_q, we_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic             ld_use;
    logic             capture;
    logic [0:WIDTH-1] opnd_a;
    logic [0:WIDTH-1] opnd_b;

    // Load-use hazard: an in-flight load targets a source this instruction reads.
    always_comb begin
        ld_use  = inValid && fwdExValid && fwdExLoad && (fwdExReg != '0) &&
                  ((fwdExReg == inRegA) || (!inUseImm && (fwdExReg == inRegB)));
        inReady = flush || (!ld_use && ((state_q == ST_EMPTY) || outReady));
        capture = inValid && inReady && !flush;
    end

    // Operand A: R0 is zero, then youngest producer (EX) wins over MA, then regfile.
    always_comb begin
        if (inRegA == '0) begin
            opnd_a = '0;
        end else if (fwdExValid && !fwdExLoad && (fwdExReg == inRegA)) begin
            opnd_a = fwdExVal;
        end else if (fwdMaValid && (fwdMaReg == inRegA)) begin
            opnd_a = fwdMaVal;
        end else begin
            opnd_a = inValA;
        end
    end

    // Operand B: the immediate bypasses the register chain entirely.
    always_comb begin
        if (inUseImm) begin
            opnd_b = inImm;
        end else if (inRegB == '0) begin
            opnd_b = '0;
        end else if (fwdExValid && !fwdExLoad && (fwdExReg == inRegB)) begin
            opnd_b = fwdExVal;
        end else if (fwdMaValid && (fwdMaReg == inRegB)) begin
            opnd_b = fwdMaVal;
        end else begin
            opnd_b = inValB;
        end
    end

    // Next-state: flush empties, capture fills, drain empties; data regs only
    // change on capture so a held entry is never re-resolved.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        ctl_d       = ctl_q;
        dst_d       = dst_q;
        we_d        = we_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else if (capture) begin
            state_d = ST_FULL;
            a_d     = opnd_a;
            b_d     = opnd_b;
            ctl_d   = inAluCtl;
            dst_d   = inDstReg;
            we_d    = inDstWe;
        end else if ((state_q == ST_FULL) && outReady) begin
            state_d = ST_EMPTY;
        end

        if (ld_use && !flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State and pipeline register update; reset beats flush and capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            a_q         <= '0;
            b_q         <= '0;
            ctl_q       <= '0;
            dst_q       <= '0;
            we_q        <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctl_q       <= ctl_d;
            dst_q       <= dst_d;
            we_q        <= we_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign outValid  = (state_q == ST_FULL);
    assign outA      = a_q;
    assign outB      = b_q;
    assign outAluCtl = ctl_q;
    assign outDstReg = dst_q;
    assign outDstWe  = we_q;
    assign stallCnt  = stall_cnt_q;

endmodule
`default_nettype wire

// File: doc/operand_select_stage.md
# operand_select_stage

Execute-stage front end of VCPU-32. It captures a decoded instruction's operands and ALU control code from the decode stage and resolves register bypassing from the EX and MA stages. It detects load-use hazards and holds the selected A/B operands in a one-entry pipeline register that feeds the ALU and shift-merge units. All operand buses use big-endian bit numbering, `[0:WIDTH-1]`, with bit 0 as the MSB.

## Interface
Parameters:
- `WIDTH`, default 32: data path width (`` `WORD_LENGTH ``).
- `RID`, default 4: register-id width (16 general registers; R0 reads as zero).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `inValid`  in  1  decode presents an instruction.
- `inReady`  out  1  stage accepts this cycle; combinational.
- `inRegA`, `inRegB`  in  RID  source register ids.
- `inValA`, `inValB`  in  WIDTH  register-file read data.
- `inImm`  in  WIDTH  immediate operand.
- `inUseImm`  in  1  B operand is `inImm`; `inRegB` is ignored.
- `inAluCtl`  in  8  ALU control code; passed through unchanged.
- `inDstReg`  in  RID  destination id.
- `inDstWe`  in  1  instruction writes `inDstReg`.
- `fwdExValid`, `fwdExLoad`  in  1 each  EX-stage result is valid / EX-stage instruction is a load (data not yet available).
- `fwdExReg`  in  RID  EX-stage destination id.
- `fwdExVal`  in  WIDTH  EX-stage result data.
- `fwdMaValid`  in  1  MA-stage result is valid.
- `fwdMaReg`  in  RID  MA-stage destination id.
- `fwdMaVal`  in  WIDTH  MA-stage result data.
- `flush`  in  1  discard held and incoming instruction.
- `outValid`  out  1  entry valid toward the ALU.
- `outReady`  in  1  ALU stage consumes the entry.
- `outA`, `outB`  out  WIDTH  resolved operands.
- `outAluCtl`  out  8  control code.
- `outDstReg`  out  RID  destination id.
- `outDstWe`  out  1  destination write enable.
- `stallCnt`  out  16  saturating count of load-use stall cycles.

## Operation
- **State machine:** states EMPTY and FULL. `outValid` is 1 exactly when the state is FULL.
- **Load-use hazard (`ldUse`):**
  - Asserted when `inValid & fwdExValid & fwdExLoad & (fwdExReg != 0)`.
  - The EX destination must also match a used source: `fwdExReg == inRegA`, or (`!inUseImm` and `fwdExReg == inRegB`).
- **Ready:** `inReady = flush | (!ldUse & (state==EMPTY | outReady))`.
- **Operand A resolution, in priority order:**
  1. `inRegA==0` → 0.
  2. EX match (`fwdExValid & !fwdExLoad & fwdExReg==inRegA`) → `fwdExVal`.
  3. MA match (`fwdMaValid & fwdMaReg==inRegA`) → `fwdMaVal`.
  4. Otherwise `inValA`.
- **Operand B resolution:** if `inUseImm`, B is `inImm`. Otherwise B uses the same chain with `inRegB`/`inValB`.
- **Capture:** when `inValid & inReady & !flush`, the output registers load the resolved operands plus ctl/dst/we, and the next state is FULL.
- **Drain:** when FULL, `outReady`, and no capture, the next state is EMPTY. Output data registers keep their values.
- **Simultaneous drain and capture:** the new entry loads and the state stays FULL.
- **Hold:** when FULL and `!outReady`, all outputs hold. Bypass is not re-resolved while holding. The EX/MA producers are stalled by the same backpressure, so their values are stable.
- **Flush:** takes priority over everything. Next state is EMPTY and the input is dropped. `inReady` is 1 so decode may retire the flushed instruction. `stallCnt` does not increment.
- **Stall counter:** `stallCnt` increments by 1 each cycle with `ldUse & !flush`, saturating at 16'hFFFF.
- **Width rules:** no arithmetic is performed on operands; ctl bits are passed unmodified.

## Timing
- **Reset:** `rst` high at a rising edge gives:
  - state EMPTY, `outValid`=0;
  - `outA`, `outB` = 0; `outAluCtl`=8'h00; `outDstReg`=0; `outDstWe`=0;
  - `stallCnt`=0.
- **Reset priority:** reset overrides flush and capture. Reset mid-hold drops the entry.
- **Latency:** 1 cycle from accepted input to `outValid`. Throughput is 1 instruction/cycle when `outReady` is held high.
- **Combinational paths:**
  - `inReady` depends on `outReady`, `flush`, and the hazard inputs.
  - No combinational path from any `in*`/`fwd*` data input to the `out*` outputs.
- **Load-use stall length:** a load-use stalls exactly while the hazard inputs indicate it. A typical single load stalls one cycle; on the following cycle MA forwarding supplies the data.

## Test plan
- **Reset and pass-through:** reset, then `inValid`=1, R1/R2 operands `inValA`=32'h0000_0005, `inValB`=32'h0000_0003, `inAluCtl`=8'h60, no forwarding → next cycle `outValid`=1, `outA`=5, `outB`=3, `outAluCtl`=8'h60.
- **Forward priority:**
  - `inRegA`=3, EX reg 3 = 32'hAAAA_0000 (not a load), MA reg 3 = 32'h5555_0000 → `outA`=32'hAAAA_0000.
  - Same with EX invalid → `outA`=32'h5555_0000.
  - `inRegA`=0 with EX reg 0 valid → `outA`=0.
- **Load-use:** EX load to R4, `inRegB`=4, `inUseImm`=0 → `inReady`=0 for 1 cycle and `stallCnt`=1. Next cycle MA reg 4 = 32'h1234_5678 → capture with `outB`=32'h1234_5678.
- **Immediate bypass:** `inUseImm`=1, `inRegB`=4 with EX load to R4 → no stall, `outB`=`inImm`.
- **Backpressure:** FULL with `outReady`=0 for 3 cycles → outputs stable and `inReady`=0. Then `outReady`=1 with a new input → back-to-back transfer and state stays FULL.
- **Flush and counter:**
  - Flush while FULL and `outReady`=0 → `outValid`=0 next cycle, input dropped.
  - Force `ldUse` for 70000 cycles → `stallCnt` saturates at 16'hFFFF.
